// File: rtl/outport_word_fifo_pkg.sv
// Shared types and constants for the output-port byte-to-word FIFO.
package outport_word_fifo_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  // Low byte used when a pending high byte is flushed on its own.
  localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h00;

  // Byte assembler state: no byte pending, or high byte latched.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } asm_state_e;

  // One FIFO entry: high byte written first, low byte second.
  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } fifo_word_t;

endpackage

// File: rtl/outport_word_fifo_mem.sv
// Word storage: one synchronous write port, one asynchronous read port, no reset.
module word_fifo_mem
  import outport_word_fifo_pkg::*;
#(
  parameter int unsigned G_DEPTH      = 8,
  parameter int unsigned G_LOG2_DEPTH = 3
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [G_LOG2_DEPTH-1:0] i_waddr,
  input  fifo_word_t              i_wdata,
  input  logic [G_LOG2_DEPTH-1:0] i_raddr,
  output fifo_word_t              o_rdata_c
);

  fifo_word_t mem_q [G_DEPTH];

  // Contents are never reset; the FIFO only exposes entries it has written.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_c = mem_q[i_raddr];

endmodule

// File: rtl/outport_word_fifo.sv
// Packs processor output-port bytes into 16-bit words and queues them in a
// first-word-fall-through FIFO with registered head, count and status flags.
module outport_word_fifo
  import outport_word_fifo_pkg::*;
#(
  parameter int unsigned G_DEPTH      = 8,
  parameter int unsigned G_LOG2_DEPTH = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [7:0]              i_v_out,
  input  logic                    i_v_wr,
  input  logic                    i_flush,
  input  logic                    i_clr_ovf,
  output logic [15:0]             o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [G_LOG2_DEPTH:0]   o_count,
  output logic                    o_full,
  output logic                    o_half,
  output logic                    o_overflow
);

  localparam int unsigned PW = G_LOG2_DEPTH;
  localparam int unsigned CW = G_LOG2_DEPTH + 1;

  asm_state_e        state_q, state_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  fifo_word_t        data_q, data_d;
  logic              valid_q, valid_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;

  logic       push_c;
  logic       push_ok_c;
  logic       pop_c;
  fifo_word_t push_word_c;
  fifo_word_t mem_rdata_c;

  // Assembler next state: a write wins over a flush; flush only pads a pending byte.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    push_c      = 1'b0;
    push_word_c = '0;
    case (state_q)
      ST_EMPTY: begin
        if (i_v_wr) begin
          hi_d    = i_v_out;
          state_d = ST_HALF;
        end
      end
      ST_HALF: begin
        if (i_v_wr) begin
          push_c      = 1'b1;
          push_word_c = '{hi: hi_q, lo: i_v_out};
          state_d     = ST_EMPTY;
        end else if (i_flush) begin
          push_c      = 1'b1;
          push_word_c = '{hi: hi_q, lo: PAD_BYTE};
          state_d     = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // FIFO bookkeeping: a pop frees a slot for a push landing in the same cycle.
  always_comb begin
    pop_c     = valid_q & i_ready;
    push_ok_c = push_c & (~full_q | pop_c);
    wr_ptr_d  = push_ok_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_c ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push_ok_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    full_d  = (count_d == CW'(G_DEPTH));
    ovf_d   = (push_c & ~push_ok_c) | (ovf_q & ~i_clr_ovf);
    // Next head: the word being written this cycle if it becomes the head, else memory.
    data_d  = data_q;
    if (count_d != '0) begin
      data_d = (push_ok_c && (rd_ptr_d == wr_ptr_q)) ? push_word_c : mem_rdata_c;
    end
  end

  // State and status registers; reset clears everything except storage contents.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_EMPTY;
      hi_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  word_fifo_mem #(
    .G_DEPTH      (G_DEPTH),
    .G_LOG2_DEPTH (G_LOG2_DEPTH)
  ) u_mem (
    .i_clk     (i_clk),
    .i_we      (push_ok_c),
    .i_waddr   (wr_ptr_q),
    .i_wdata   (push_word_c),
    .i_raddr   (rd_ptr_d),
    .o_rdata_c (mem_rdata_c)
  );

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_count    = count_q;
  assign o_full     = full_q;
  assign o_half     = (state_q == ST_HALF);
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_outport_word_fifo.sv
// Bench for outport_word_fifo: directed vector table, corner sequences and a
// random stream checked against a queue-based reference model.
module tb_outport_word_fifo;

  localparam int DEPTH = 8;

  logic        i_clk;
  logic        i_rst;
  logic [7:0]  i_v_out;
  logic        i_v_wr;
  logic        i_flush;
  logic        i_clr_ovf;
  logic        i_ready;
  logic [15:0] o_data;
  logic        o_valid;
  logic [3:0]  o_count;
  logic        o_full;
  logic        o_half;
  logic        o_overflow;

  int tests;
  int fails;

  // Reference model: list of stored words plus assembler and flag state.
  logic [15:0] m_q[$];
  logic        m_half;
  logic [7:0]  m_hi;
  logic        m_ovf;
  logic [15:0] m_last;
  int          n_pops;

  typedef struct {
    logic [7:0]  vo;
    logic        wr;
    logic        fl;
    logic        clr;
    logic        rdy;
    logic [15:0] data;
    logic        valid;
    logic [3:0]  cnt;
    logic        half;
    logic        ovf;
  } vec_t;

  vec_t vecs[11];

  outport_word_fifo #(.G_DEPTH(8), .G_LOG2_DEPTH(3)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_v_out    (i_v_out),
    .i_v_wr     (i_v_wr),
    .i_flush    (i_flush),
    .i_clr_ovf  (i_clr_ovf),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_half     (o_half),
    .o_overflow (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [23:0] outs();
    return {o_data, o_valid, o_count, o_full, o_half, o_overflow};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_half = 1'b0;
    m_hi   = 8'h00;
    m_ovf  = 1'b0;
    m_last = 16'h0000;
  endtask

  // Apply one cycle of inputs, advance the model, clock, then compare to the model.
  task automatic drive(input logic [7:0] vo, input logic wr, input logic fl,
                       input logic clr, input logic rdy);
    logic [15:0] w;
    logic        do_push;
    logic        do_pop;
    logic        acc;
    logic [15:0] dropped;
    i_v_out   = vo;
    i_v_wr    = wr;
    i_flush   = fl;
    i_clr_ovf = clr;
    i_ready   = rdy;
    w         = 16'h0000;
    do_push   = 1'b0;
    if (wr) begin
      if (m_half) begin
        w = {m_hi, vo}; do_push = 1'b1; m_half = 1'b0;
      end else begin
        m_hi = vo; m_half = 1'b1;
      end
    end else if (fl && m_half) begin
      w = {m_hi, 8'h00}; do_push = 1'b1; m_half = 1'b0;
    end
    do_pop = (m_q.size() != 0) && rdy;
    acc    = do_push && ((m_q.size() < DEPTH) || do_pop);
    if (do_pop) begin
      dropped = m_q.pop_front();
      n_pops++;
    end
    if (acc) m_q.push_back(w);
    if (do_push && !acc) m_ovf = 1'b1;
    else if (clr)        m_ovf = 1'b0;
    if (m_q.size() != 0) m_last = m_q[0];
    @(posedge i_clk);
    #1;
    check("model", 32'(outs()),
          32'({m_last, (m_q.size() != 0), 4'(m_q.size()), (m_q.size() == DEPTH), m_half, m_ovf}));
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string name);
    i_v_wr = 1'b0; i_flush = 1'b0; i_clr_ovf = 1'b0; i_ready = 1'b0;
    #2;
    i_rst = 1'b0;
    #1;
    check(name, 32'(outs()), 32'h0);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0; n_pops = 0;
    model_reset();
    i_rst = 1'b0; i_v_out = 8'h00; i_v_wr = 1'b0; i_flush = 1'b0;
    i_clr_ovf = 1'b0; i_ready = 1'b0;
    #3;
    check("reset_state", 32'(outs()), 32'h0);
    #9;
    i_rst = 1'b1;

    // Directed table: byte packing, pops, flush padding, flush vs write priority.
    vecs[0]  = '{8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[1]  = '{8'h34, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 4'd1, 1'b0, 1'b0};
    vecs[2]  = '{8'h56, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[3]  = '{8'h78, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5678, 1'b1, 4'd1, 1'b0, 1'b0};
    vecs[4]  = '{8'h99, 1'b0, 1'b1, 1'b0, 1'b1, 16'h5678, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[5]  = '{8'hAB, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5678, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[6]  = '{8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 16'hAB00, 1'b1, 4'd1, 1'b0, 1'b0};
    vecs[7]  = '{8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 16'hAB00, 1'b1, 4'd1, 1'b0, 1'b0};
    vecs[8]  = '{8'hCD, 1'b1, 1'b1, 1'b0, 1'b1, 16'hAB00, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[9]  = '{8'hEF, 1'b1, 1'b1, 1'b0, 1'b0, 16'hCDEF, 1'b1, 4'd1, 1'b0, 1'b0};
    vecs[10] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'hCDEF, 1'b0, 4'd0, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].vo, vecs[i].wr, vecs[i].fl, vecs[i].clr, vecs[i].rdy);
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vecs[i].data, vecs[i].valid, vecs[i].cnt, 1'b0, vecs[i].half, vecs[i].ovf}));
    end

    // Nine words into a depth-8 FIFO with no reader: the ninth is dropped.
    for (int i = 1; i <= 9; i++) begin
      drive(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      drive(8'(8'h10 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("ovf_count", 32'(o_count), 32'd8);
    check("ovf_full", 32'(o_full), 32'd1);
    check("ovf_flag", 32'(o_overflow), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("drain%0d", k), 32'(o_data), 32'({8'(k), 8'(8'h10 + k)}));
      drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("drain_empty", 32'({o_valid, o_count}), 32'h0);

    // Full FIFO: completing write and pop in the same cycle.
    drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_ovf", 32'(o_overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(8'(8'hA0 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      drive(8'(8'h50 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    drive(8'hEE, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    check("fullpp_state", 32'({o_count, o_full, o_overflow}), 32'({4'd8, 1'b1, 1'b0}));
    check("fullpp_head", 32'(o_data), 32'h0000A151);

    // Reset with a pending byte and three stored words.
    pulse_reset("rst_clean");
    for (int i = 0; i < 3; i++) begin
      drive(8'(8'h30 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      drive(8'(8'h40 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    drive(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst", 32'({o_count, o_half}), 32'({4'd3, 1'b1}));
    pulse_reset("rst_mid_word");
    drive(8'hCD, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(8'hEF, 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_rst", 32'({o_data, o_valid, o_count}), 32'({16'hCDEF, 1'b1, 4'd1}));

    // Random stream across many pointer wraps.
    n_pops = 0;
    for (int c = 0; c < 3000; c++) begin
      drive(8'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1));
    end
    check("wrap_pops", 32'(n_pops > 256), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/outport_word_fifo.md
OUTPORT_WORD_FIFO -- requirements
Module: outport_word_fifo

Interface
REQ-001 The block SHALL have one clock, i_clk, and an asynchronous, active-low reset, i_rst.
REQ-002 Parameter G_DEPTH SHALL default to 8 and SHALL be the FIFO depth in 16-bit words; only powers of 2 from 2 to 256 are legal.
REQ-003 Parameter G_LOG2_DEPTH SHALL default to 3 and SHALL equal log2(G_DEPTH).
REQ-004 i_clk  input  1  processor clock; every register is updated on its rising edge.
REQ-005 i_rst  input  1  asynchronous reset, active low.
REQ-006 i_v_out  input  8  processor output-port byte.
REQ-007 i_v_wr  input  1  one-cycle output-port write strobe that qualifies i_v_out.
REQ-008 i_flush  input  1  pad and push a pending half word.
REQ-009 i_clr_ovf  input  1  clear o_overflow.
REQ-010 o_data  output  16  head-of-FIFO word.
REQ-011 o_valid  output  1  o_data is valid.
REQ-012 i_ready  input  1  downstream accepts o_data.
REQ-013 o_count  output  G_LOG2_DEPTH+1  number of words stored.
REQ-014 o_full  output  1  o_count equals G_DEPTH.
REQ-015 o_half  output  1  a high byte is latched and waiting for its low byte.
REQ-016 o_overflow  output  1  sticky flag: at least one word was dropped.

Function
REQ-017 The assembler SHALL have two states, EMPTY and HALF, with o_half asserted only in HALF.
REQ-018 On i_v_wr in EMPTY, the block SHALL latch i_v_out as the high byte and move to HALF.
REQ-019 On i_v_wr in HALF, the block SHALL push {high byte, i_v_out} and return to EMPTY.
REQ-020 On i_flush without i_v_wr in HALF, the block SHALL push {high byte, 8'h00} and return to EMPTY.
REQ-021 i_flush in EMPTY SHALL have no effect.
REQ-022 When i_flush and i_v_wr occur in the same cycle, i_v_wr SHALL be processed and i_flush ignored.
REQ-023 A pop SHALL occur when o_valid and i_ready are both high; o_data SHALL then advance to the next word on the following cycle.
REQ-024 A push SHALL be accepted when o_full is low, or when o_full is high and a pop occurs in the same cycle.
REQ-025 A push that is not accepted SHALL discard the word, set o_overflow, and still return the assembler to EMPTY.
REQ-026 The FIFO SHALL be first-word-fall-through: a word pushed in cycle N SHALL appear on o_valid/o_data in cycle N+1, with no same-cycle bypass.
REQ-027 A simultaneous push and pop SHALL leave o_count unchanged.
REQ-028 Read and write pointers SHALL be G_LOG2_DEPTH bits wide and wrap modulo G_DEPTH; o_count SHALL be exact from 0 to G_DEPTH.
REQ-029 o_overflow SHALL be cleared by i_clr_ovf; if an overflow and i_clr_ovf occur in the same cycle, set SHALL win.
REQ-030 o_data SHALL hold its last value while o_valid is low.

Reset
REQ-031 Reset SHALL force the following, independently of i_clk:
- assembler to EMPTY
- pointers and o_count to 0
- o_valid, o_full, o_half and o_overflow to 0
- o_data to 16'h0000
REQ-032 Reset asserted mid-word SHALL discard the pending high byte and all stored words.
REQ-033 Storage memory contents are not reset; they SHALL never be observable while o_valid is low.

Structure
REQ-034 A shared package SHALL hold the assembler state encoding (EMPTY, HALF) and the pad-byte constant 8'h00.
REQ-035 The block SHALL use one sub-module, word_fifo_mem: a G_DEPTH x 16 register array with one write port and an asynchronous read port.

Verification
REQ-036 Bytes 12,34,56,78 with idle i_ready=1 -> o_data 16'h1234 then 16'h5678, each one cycle after its completing write.
REQ-037 Bytes AB then i_flush -> one word 16'hAB00 and o_half low afterwards; a second i_flush -> no push.
REQ-038 i_ready=0 and 9 words pushed with G_DEPTH=8 -> o_count=8, o_full=1, o_overflow=1, 9th word absent; draining returns words 1-8 in order.
REQ-039 FIFO full, with a completing write and a pop in the same cycle -> push accepted, o_count stays 8, o_overflow stays 0.
REQ-040 Reset pulse while o_half=1 and o_count=3 -> all outputs 0 immediately; next bytes CD,EF -> 16'hCDEF.
REQ-041 More than 256 words streamed with random i_ready -> output sequence matches a reference queue across pointer wrap.
